// File: rtl/multiword_add_sequencer.sv
// Operand/result pipeline around an external 32-bit ripple adder that chains carries across beats.
// Optional MULTIWORD_ADD_PROTOCOL_CHECK_EN adds out_err flagging truncated packets and orphan beats.
module multiword_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_first,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_first,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_zero
`ifdef MULTIWORD_ADD_PROTOCOL_CHECK_EN
    ,
    output logic             out_err
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_sub;
    logic             r_s1_first;
    logic             r_s1_last;
    logic             r_sub_q;
    logic             r_carry_q;
    logic             r_zero_acc;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_first;
    logic             r_out_last;
    logic             r_out_cout;
    logic             r_out_overflow;
    logic             r_out_zero;

    logic             w_accept;
    logic             w_s1_advance;
    logic             w_eff_first;
    logic             w_eff_sub;
    logic [WIDTH-1:0] w_add_b;
    logic             w_zero_next;
    logic             w_overflow;

    assign w_s1_advance = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_accept     = in_valid && in_ready;

    // An orphan beat arriving in IDLE is promoted to a packet start.
    assign w_eff_first  = in_first || (r_state == ST_IDLE);
    assign w_eff_sub    = w_eff_first ? in_sub : r_sub_q;

    assign w_add_b      = r_s1_sub ? ~r_s1_b : r_s1_b;
    assign add_a        = r_s1_a;
    assign add_b        = w_add_b;
    assign add_cin      = r_s1_first ? r_s1_sub : r_carry_q;

    assign w_zero_next  = (r_s1_first ? 1'b1 : r_zero_acc) && (add_sum == '0);
    assign w_overflow   = r_s1_last && (r_s1_a[WIDTH-1] == w_add_b[WIDTH-1])
                          && (add_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = in_last ? ST_IDLE : ST_IN_PKT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_s1_sub       <= 1'b0;
            r_s1_first     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_sub_q        <= 1'b0;
            r_carry_q      <= 1'b0;
            r_zero_acc     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_sum      <= '0;
            r_out_first    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_cout     <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_sub   <= w_eff_sub;
                r_s1_first <= w_eff_first;
                r_s1_last  <= in_last;
                if (w_eff_first) begin
                    r_sub_q <= in_sub;
                end
            end else if (w_s1_advance) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_advance) begin
                r_carry_q      <= add_cout;
                r_zero_acc     <= w_zero_next;
                r_out_valid    <= 1'b1;
                r_out_sum      <= add_sum;
                r_out_first    <= r_s1_first;
                r_out_last     <= r_s1_last;
                r_out_cout     <= add_cout;
                r_out_overflow <= w_overflow;
                r_out_zero     <= r_s1_last && w_zero_next;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_first    = r_out_first;
    assign out_last     = r_out_last;
    assign out_cout     = r_out_cout;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;

`ifdef MULTIWORD_ADD_PROTOCOL_CHECK_EN
    logic r_s1_err;
    logic r_out_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_err  <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_err <= (in_first && (r_state == ST_IN_PKT))
                            || (!in_first && (r_state == ST_IDLE));
            end
            if (w_s1_advance) begin
                r_out_err <= r_s1_err;
            end
        end
    end

    assign out_err = r_out_err;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer: directed beats with hand-computed results,
// a behavioural 32-bit adder on the add_* ports, and a monitor popping expectations on each result handshake.
module tb_multiword_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        in_first;
    logic        in_last;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_first;
    logic        out_last;
    logic        out_cout;
    logic        out_overflow;
    logic        out_zero;
    logic        w_err;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_first     (in_first),
        .in_last      (in_last),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_first    (out_first),
        .out_last     (out_last),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
`ifdef MULTIWORD_ADD_PROTOCOL_CHECK_EN
        ,
        .out_err      (w_err)
`endif
    );

`ifndef MULTIWORD_ADD_PROTOCOL_CHECK_EN
    assign w_err = 1'b0;
`endif

    // The external combinational adder the stage drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        first;
        logic        last;
        logic        ovf;
        logic        zero;
        logic        err;
    } res_t;

    res_t exp_q[$];
    res_t mon_act;
    res_t mon_exp;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   acc_cnt = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    always @(negedge clk) begin
        if (in_valid && in_ready && rst_n) acc_cnt++;
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready) begin
            mon_act = {out_sum, out_cout, out_first, out_last, out_overflow, out_zero, w_err};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(mon_act), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_beat", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    task automatic expect_beat(input logic [31:0] s, input logic c, f, l, o, z, er);
`ifndef MULTIWORD_ADD_PROTOCOL_CHECK_EN
        er = 1'b0;
`endif
        exp_q.push_back({s, c, f, l, o, z, er});
    endtask

    task automatic send(input logic [31:0] a, b, input logic sub, first, last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_first = first;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_state",
              64'({out_valid, in_ready, out_sum, out_cout, out_first, out_last,
                   out_overflow, out_zero, add_cin, w_err}),
              64'({2'b01, 39'd0}));
        @(posedge clk);
        #1;

        // Single beat, wraps to zero with carry out; result valid on the second edge.
        expect_beat(32'h0000_0000, 1, 1, 1, 0, 1, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 1);
        @(negedge clk);
        check("latency_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_edge2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // 64-bit add, carry propagates into the upper word.
        expect_beat(32'h0000_0000, 1, 1, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0);
        expect_beat(32'h0000_0001, 0, 0, 1, 0, 0, 0);
        send(32'h0000_0000, 32'h0000_0000, 0, 0, 1);

        // 64-bit subtract; in_sub on the second beat must be ignored.
        expect_beat(32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
        send(32'h0000_0000, 32'h0000_0001, 1, 1, 0);
        expect_beat(32'h0000_0000, 1, 0, 1, 0, 0, 0);
        send(32'h0000_0001, 32'h0000_0000, 0, 0, 1);

        // Signed overflow on subtract.
        expect_beat(32'h7FFF_FFFF, 1, 1, 1, 1, 0, 0);
        send(32'h8000_0000, 32'h0000_0001, 1, 1, 1);

        // 96-bit X-X: every word zero, zero flag only on the last beat.
        expect_beat(32'h0000_0000, 1, 1, 0, 0, 0, 0);
        send(32'h0000_0005, 32'h0000_0005, 1, 1, 0);
        expect_beat(32'h0000_0000, 1, 0, 0, 0, 0, 0);
        send(32'h0000_0006, 32'h0000_0006, 0, 0, 0);
        expect_beat(32'h0000_0000, 1, 0, 1, 0, 1, 0);
        send(32'h0000_0007, 32'h0000_0007, 0, 0, 1);

        // Orphan beat in IDLE: treated as first, sub taken from it.
        expect_beat(32'h0000_0002, 1, 1, 1, 0, 0, 1);
        send(32'h0000_0005, 32'h0000_0003, 1, 0, 1);

        // Truncated packet: new first in IN_PKT restarts the carry chain.
        expect_beat(32'h0000_0000, 1, 1, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0);
        expect_beat(32'h0000_0005, 0, 1, 1, 0, 0, 1);
        send(32'h0000_0002, 32'h0000_0003, 0, 1, 1);

        drain();

        // Backpressure: output stalled for 5 cycles under continuous input.
        out_ready = 1'b0;
        acc_base  = acc_cnt;
        fork
            begin
                expect_beat(32'h0000_0002, 0, 1, 1, 0, 0, 0);
                send(32'h0000_0001, 32'h0000_0001, 0, 1, 1);
                expect_beat(32'h0000_001E, 0, 1, 1, 0, 0, 0);
                send(32'h0000_000A, 32'h0000_0014, 0, 1, 1);
                expect_beat(32'h8000_0000, 0, 1, 1, 1, 0, 0);
                send(32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 1);
                expect_beat(32'h0000_0000, 0, 1, 1, 0, 1, 0);
                send(32'h0000_0000, 32'h0000_0000, 0, 1, 1);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_hold", 64'({in_ready, out_valid, out_sum}), 64'({2'b01, 32'h0000_0002}));
                    check("bp_accepts", 64'(acc_cnt - acc_base), 64'd2);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-packet: second beat in S1 is discarded, carry chain cleared.
        expect_beat(32'h0000_0000, 1, 1, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0);
        send(32'h0000_0000, 32'h0000_0000, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_state", 64'({out_valid, in_ready, add_cin}), 64'(3'b010));
        @(posedge clk);
        #1;
        expect_beat(32'h0000_0005, 0, 1, 1, 0, 0, 0);
        send(32'h0000_0002, 32'h0000_0003, 0, 1, 1);

        drain();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
